// File: rtl/mcdf_arbiter_rr.sv
// rtl/mcdf_arbiter_rr.sv - priority + round-robin packet arbiter for the MCDF formatter path
//
// Purpose: picks one slave channel per packet (lowest priority value wins, ties
// broken round-robin from rr_ptr), then routes that channel's beats to the
// formatter until the latched package length has been transferred.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   slv_prio_i           per-channel priority, PRIO_W bits each (lower = higher priority)
//   slv_pkglen_i         per-channel package length code, LEN_W bits each (beats = code+1)
//   slv_req_i            per-channel packet request
//   slv_val_i            per-channel data valid
//   slv_data_i           per-channel data, DW bits each
//   f2a_id_req_i         formatter ready for a new packet
//   f2a_ack_i            formatter accepts the current beat
//   a2s_ack_o            per-channel beat acknowledge
//   a2f_gnt_o            packet grant active
//   a2f_id_o             granted channel
//   a2f_val_o            beat valid toward formatter
//   a2f_data_o           beat data toward formatter
//   a2f_pkglen_sel_o     latched package length code of the granted packet
module mcdf_arbiter_rr #(
  parameter int NUM_CH = 4,
  parameter int DW     = 32,
  parameter int PRIO_W = 2,
  parameter int LEN_W  = 3,
  localparam int CHW   = ($clog2(NUM_CH) < 1) ? 1 : $clog2(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_CH*PRIO_W-1:0] slv_prio_i,
  input  logic [NUM_CH*LEN_W-1:0]  slv_pkglen_i,
  input  logic [NUM_CH-1:0]        slv_req_i,
  input  logic [NUM_CH-1:0]        slv_val_i,
  input  logic [NUM_CH*DW-1:0]     slv_data_i,
  input  logic                     f2a_id_req_i,
  input  logic                     f2a_ack_i,
  output logic [NUM_CH-1:0]        a2s_ack_o,
  output logic                     a2f_gnt_o,
  output logic [CHW-1:0]           a2f_id_o,
  output logic                     a2f_val_o,
  output logic [DW-1:0]            a2f_data_o,
  output logic [LEN_W-1:0]         a2f_pkglen_sel_o
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [LEN_W:0] CNT_ONE = {{LEN_W{1'b0}}, 1'b1};

  state_t            state;
  logic [LEN_W:0]    beat_cnt;
  logic [CHW-1:0]    rr_ptr;

  logic [PRIO_W-1:0] min_prio;
  logic [NUM_CH-1:0] cand;
  logic [CHW-1:0]    win_hi;
  logic [CHW-1:0]    win_lo;
  logic              hi_found;
  logic [CHW-1:0]    win_id;
  logic [LEN_W-1:0]  win_len;
  logic              sel_val;
  logic [DW-1:0]     sel_data;
  logic              xfer;
  logic              beat_done;
  logic [CHW-1:0]    next_ptr;

  // Candidates are the requesting channels sharing the smallest priority value.
  // min_prio starts at the all-ones maximum, which is itself a legal priority.
  always_comb begin
    min_prio = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (slv_req_i[k] && (slv_prio_i[k*PRIO_W +: PRIO_W] < min_prio))
        min_prio = slv_prio_i[k*PRIO_W +: PRIO_W];
    end
    for (int k = 0; k < NUM_CH; k++)
      cand[k] = slv_req_i[k] && (slv_prio_i[k*PRIO_W +: PRIO_W] == min_prio);
  end

  // Rotating search split into two linear scans: the lowest candidate at or
  // above rr_ptr wins; if there is none, wrap to the lowest candidate overall.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    hi_found = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (cand[k]) begin
        win_lo = CHW'(k);
        if (k >= int'(rr_ptr)) begin
          win_hi   = CHW'(k);
          hi_found = 1'b1;
        end
      end
    end
    win_id  = hi_found ? win_hi : win_lo;
    win_len = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (win_id == CHW'(k))
        win_len = slv_pkglen_i[k*LEN_W +: LEN_W];
    end
  end

  // Beat path: combinational route from the granted channel, forced to zero
  // whenever no packet is in flight.
  always_comb begin
    sel_val  = 1'b0;
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (a2f_id_o == CHW'(k)) begin
        sel_val  = slv_val_i[k];
        sel_data = slv_data_i[k*DW +: DW];
      end
    end
    xfer       = (state == XFER);
    a2f_val_o  = xfer & sel_val;
    a2f_data_o = xfer ? sel_data : '0;
    a2s_ack_o  = '0;
    for (int k = 0; k < NUM_CH; k++)
      a2s_ack_o[k] = xfer && (a2f_id_o == CHW'(k)) && sel_val && f2a_ack_i;
  end

  assign beat_done = a2f_val_o & f2a_ack_i;
  assign next_ptr  = (a2f_id_o == CHW'(NUM_CH - 1)) ? '0 : a2f_id_o + CHW'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state            <= IDLE;
      a2f_gnt_o        <= 1'b0;
      a2f_id_o         <= '0;
      a2f_pkglen_sel_o <= '0;
      beat_cnt         <= '0;
      rr_ptr           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (f2a_id_req_i && (|slv_req_i)) begin
            state            <= XFER;
            a2f_gnt_o        <= 1'b1;
            a2f_id_o         <= win_id;
            a2f_pkglen_sel_o <= win_len;
            beat_cnt         <= {1'b0, win_len} + CNT_ONE;
          end
        end
        XFER: begin
          // Request, priority and length inputs are deliberately not looked at
          // here: the packet runs to completion once granted.
          if (beat_done) begin
            if (beat_cnt == CNT_ONE) begin
              state     <= IDLE;
              a2f_gnt_o <= 1'b0;
              rr_ptr    <= next_ptr;
              beat_cnt  <= '0;
            end else begin
              beat_cnt <= beat_cnt - CNT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcdf_arbiter_rr.sv
// tb/tb_mcdf_arbiter_rr.sv - self-checking bench for mcdf_arbiter_rr (4, 2 and 8 channel builds)
module tb_mcdf_arbiter_rr;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [7:0]   req, val;
  logic [15:0]  prio;
  logic [23:0]  len;
  logic [511:0] d64;
  logic [127:0] d32;
  logic         idreq, fack;

  always_comb
    for (int k = 0; k < 4; k++) d32[k*32 +: 32] = d64[k*64 +: 32];

  logic [3:0]  ack4; logic gnt4; logic [1:0] id4; logic v4; logic [31:0] data4; logic [2:0] len4;
  logic [1:0]  ack2; logic gnt2; logic [0:0] id2; logic v2; logic [63:0] data2; logic [2:0] len2;
  logic [7:0]  ack8; logic gnt8; logic [2:0] id8; logic v8; logic [63:0] data8; logic [2:0] len8;

  mcdf_arbiter_rr #(.NUM_CH(4), .DW(32)) dut4 (
    .clk_i(clk), .rstn_i(rstn), .slv_prio_i(prio[7:0]), .slv_pkglen_i(len[11:0]),
    .slv_req_i(req[3:0]), .slv_val_i(val[3:0]), .slv_data_i(d32),
    .f2a_id_req_i(idreq), .f2a_ack_i(fack), .a2s_ack_o(ack4), .a2f_gnt_o(gnt4),
    .a2f_id_o(id4), .a2f_val_o(v4), .a2f_data_o(data4), .a2f_pkglen_sel_o(len4));

  mcdf_arbiter_rr #(.NUM_CH(2), .DW(64)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .slv_prio_i(prio[3:0]), .slv_pkglen_i(len[5:0]),
    .slv_req_i(req[1:0]), .slv_val_i(val[1:0]), .slv_data_i(d64[127:0]),
    .f2a_id_req_i(idreq), .f2a_ack_i(fack), .a2s_ack_o(ack2), .a2f_gnt_o(gnt2),
    .a2f_id_o(id2), .a2f_val_o(v2), .a2f_data_o(data2), .a2f_pkglen_sel_o(len2));

  mcdf_arbiter_rr #(.NUM_CH(8), .DW(64)) dut8 (
    .clk_i(clk), .rstn_i(rstn), .slv_prio_i(prio), .slv_pkglen_i(len),
    .slv_req_i(req), .slv_val_i(val), .slv_data_i(d64),
    .f2a_id_req_i(idreq), .f2a_ack_i(fack), .a2s_ack_o(ack8), .a2f_gnt_o(gnt8),
    .a2f_id_o(id8), .a2f_val_o(v8), .a2f_data_o(data8), .a2f_pkglen_sel_o(len8));

  int checks = 0;
  int failures = 0;
  int beats4 = 0;
  int nch[3] = '{4, 2, 8};

  // Reference model per build: packet in flight, granted id, length code,
  // remaining beats, round-robin start point.
  bit m_busy[3];
  int m_id[3], m_len[3], m_cnt[3], m_rr[3];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner = among requesters with the smallest priority value, the one
  // reached first when counting upward from rr (circular distance).
  function automatic int pick(int n, int rr);
    int minp = 99;
    int best = -1;
    int bestd = 99;
    int d;
    for (int c = 0; c < n; c++)
      if (req[c] && int'(prio[c*2 +: 2]) < minp) minp = int'(prio[c*2 +: 2]);
    for (int c = 0; c < n; c++) begin
      if (req[c] && int'(prio[c*2 +: 2]) == minp) begin
        d = (c - rr + n) % n;
        if (d < bestd) begin bestd = d; best = c; end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 0; m_id[i] = 0; m_len[i] = 0; m_cnt[i] = 0; m_rr[i] = 0;
    end
  endtask

  task automatic check_all();
    logic [63:0] og, oi, ol, ov, od, oa, ed, ea;
    logic ev;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin og = 64'(gnt4); oi = 64'(id4); ol = 64'(len4); ov = 64'(v4); od = 64'(data4); oa = 64'(ack4); end
        1: begin og = 64'(gnt2); oi = 64'(id2); ol = 64'(len2); ov = 64'(v2); od = data2; oa = 64'(ack2); end
        default: begin og = 64'(gnt8); oi = 64'(id8); ol = 64'(len8); ov = 64'(v8); od = data8; oa = 64'(ack8); end
      endcase
      ev = m_busy[i] && val[m_id[i]];
      if (!m_busy[i]) ed = 64'd0;
      else if (i == 0) ed = {32'd0, d64[m_id[i]*64 +: 32]};
      else ed = d64[m_id[i]*64 +: 64];
      ea = (ev && fack) ? (64'd1 << m_id[i]) : 64'd0;
      chk($sformatf("n%0d_gnt", nch[i]), og, 64'(m_busy[i]));
      chk($sformatf("n%0d_id", nch[i]), oi, 64'(m_id[i]));
      chk($sformatf("n%0d_pkglen", nch[i]), ol, 64'(m_len[i]));
      chk($sformatf("n%0d_val", nch[i]), ov, 64'(ev));
      chk($sformatf("n%0d_data", nch[i]), od, ed);
      chk($sformatf("n%0d_ack", nch[i]), oa, ea);
    end
    if (ack4 != 4'd0) beats4++;
  endtask

  // One clock: check outputs at the falling edge, predict the next state from
  // the same inputs, commit it at the rising edge, then release inputs at +1.
  task automatic tick();
    bit nb[3];
    int ni[3], nl[3], nc[3], nr[3];
    int w;
    @(negedge clk);
    check_all();
    for (int i = 0; i < 3; i++) begin
      nb[i] = m_busy[i]; ni[i] = m_id[i]; nl[i] = m_len[i]; nc[i] = m_cnt[i]; nr[i] = m_rr[i];
      if (!m_busy[i]) begin
        if (idreq) begin
          w = pick(nch[i], m_rr[i]);
          if (w >= 0) begin
            nb[i] = 1; ni[i] = w; nl[i] = int'(len[w*3 +: 3]); nc[i] = nl[i] + 1;
          end
        end
      end else if (val[m_id[i]] && fack) begin
        if (m_cnt[i] == 1) begin
          nb[i] = 0; nr[i] = (m_id[i] + 1) % nch[i];
        end else begin
          nc[i] = m_cnt[i] - 1;
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = nb[i]; m_id[i] = ni[i]; m_len[i] = nl[i]; m_cnt[i] = nc[i]; m_rr[i] = nr[i];
    end
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_gnt", 64'(gnt4), 64'd0);
    chk("rst_val", 64'(v4), 64'd0);
    chk("rst_data", 64'(data4), 64'd0);
    chk("rst_ack", 64'(ack4), 64'd0);
    chk("rst_id", 64'(id4), 64'd0);
    chk("rst_pkglen", 64'(len4), 64'd0);
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic rnd_data();
    for (int k = 0; k < 16; k++) d64[k*32 +: 32] = $urandom;
  endtask

  initial begin
    rstn = 1'b1; req = '0; val = '0; prio = '0; len = '0; d64 = '0; idreq = 1'b0; fack = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Fixed priority: ch0 has the smallest value.
    rnd_data();
    prio = 16'hFFE4; req = 8'hFF; len = '0; val = 8'hFF; fack = 1'b0; idreq = 1'b1;
    tick();
    idreq = 1'b0;
    chk("r39_gnt", 64'(gnt4), 64'd1);
    chk("r39_id", 64'(id4), 64'd0);
    fack = 1'b1;
    tick();
    chk("r39_done", 64'(gnt4), 64'd0);

    // Equal priority: round-robin order 0,1,2,3,0 with single-beat packets.
    do_reset();
    prio = 16'h5555; req = 8'hFF; len = '0; val = 8'hFF; fack = 1'b1; idreq = 1'b1;
    for (int p = 0; p < 5; p++) begin
      tick();
      chk($sformatf("r40_id%0d", p), 64'(id4), 64'(p % 4));
      chk($sformatf("r40_gnt%0d", p), 64'(gnt4), 64'd1);
      rnd_data();
      tick();
    end
    idreq = 1'b0;

    // Four-beat packet on ch2 with a valid stall in the middle.
    req = 8'h04; len = 24'(3 << 6); idreq = 1'b1;
    tick();
    idreq = 1'b0;
    chk("r41_id", 64'(id4), 64'd2);
    beats4 = 0;
    for (int i = 0; i < 6; i++) begin
      val = (i == 1) ? 8'hFB : 8'hFF;
      tick();
      if (i == 1) begin
        chk("r41_hold_id", 64'(id4), 64'd2);
        chk("r41_hold_gnt", 64'(gnt4), 64'd1);
      end
    end
    chk("r41_beats", 64'(beats4), 64'd4);
    chk("r41_idle", 64'(gnt4), 64'd0);

    // Priority/request changes during a packet do not disturb it.
    req = 8'h08; prio = 16'h5555; len = 24'(2 << 9); val = 8'hFF; fack = 1'b0; idreq = 1'b1;
    tick();
    idreq = 1'b0;
    chk("r42_id", 64'(id4), 64'd3);
    prio[3:2] = 2'b00; req = 8'h0A; idreq = 1'b1;
    tick();
    idreq = 1'b0;
    chk("r42_hold_id", 64'(id4), 64'd3);
    chk("r42_hold_gnt", 64'(gnt4), 64'd1);
    fack = 1'b1;
    repeat (3) tick();
    chk("r42_done", 64'(gnt4), 64'd0);
    idreq = 1'b1;
    tick();
    idreq = 1'b0;
    chk("r42_next_id", 64'(id4), 64'd1);
    tick();

    // Reset in the middle of a five-beat packet; pointer restarts at 0.
    do_reset();
    prio = 16'h5555; len = '0; req = 8'h02; val = 8'hFF; fack = 1'b1; idreq = 1'b1;
    tick();
    idreq = 1'b0;
    tick();
    req = 8'h04; len = 24'(4 << 6); idreq = 1'b1;
    tick();
    idreq = 1'b0;
    chk("r43_id", 64'(id4), 64'd2);
    tick();
    tick();
    do_reset();
    req = 8'hFF; idreq = 1'b1;
    tick();
    idreq = 1'b0;
    chk("r43_restart_id", 64'(id4), 64'd0);
    tick();

    // Per-channel routing on every channel of the wide builds.
    len = '0; prio = 16'h5555; val = 8'hFF; fack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req = 8'(1 << c);
      rnd_data();
      idreq = 1'b1;
      tick();
      idreq = 1'b0;
      chk($sformatf("r44_id%0d", c), 64'(id8), 64'(c));
      tick();
    end

    // Randomized traffic against the model.
    repeat (400) begin
      req = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = '0;
      prio  = 16'($urandom);
      len   = 24'($urandom);
      val   = 8'($urandom | $urandom);
      fack  = 1'($urandom_range(0, 1));
      idreq = 1'($urandom_range(0, 1));
      rnd_data();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcdf_arbiter_rr.md
MCDF_ARBITER_RR -- requirements
Module: mcdf_arbiter_rr

Interface
REQ-001 Parameter NUM_CH, default 4, number of slave channels (legal range 2..8).
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter PRIO_W, default 2, priority field width per channel; lower value = higher priority.
REQ-004 Parameter LEN_W, default 3, package-length field width per channel.
REQ-005 Derived CHW = max(1, clog2(NUM_CH)), channel-id width.
REQ-006 clk_i  in  1  clock; all state updates on the rising edge.
REQ-007 rstn_i  in  1  reset, asynchronous, active-low.
REQ-008 slv_prio_i  in  NUM_CH*PRIO_W  per-channel priority; channel k occupies bits [k*PRIO_W +: PRIO_W].
REQ-009 slv_pkglen_i  in  NUM_CH*LEN_W  per-channel package length code; packet beats = code+1.
REQ-010 slv_req_i  in  NUM_CH  per-channel request to send a packet.
REQ-011 slv_val_i  in  NUM_CH  per-channel data-valid.
REQ-012 slv_data_i  in  NUM_CH*DW  per-channel data; channel k occupies bits [k*DW +: DW].
REQ-013 f2a_id_req_i  in  1  formatter ready to accept a new packet.
REQ-014 f2a_ack_i  in  1  formatter accepts the current beat.
REQ-015 a2s_ack_o  out  NUM_CH  per-channel beat acknowledge.
REQ-016 a2f_gnt_o  out  1  a packet grant is active.
REQ-017 a2f_id_o  out  CHW  granted channel number.
REQ-018 a2f_val_o  out  1  beat valid toward the formatter.
REQ-019 a2f_data_o  out  DW  beat data.
REQ-020 a2f_pkglen_sel_o  out  LEN_W  latched package length code of the granted packet.

Function
REQ-021 Two states: IDLE and XFER, one-hot or binary encoding.
REQ-022 In IDLE, f2a_id_req_i=1 with any slv_req_i bit set: arbitrate, then enter XFER on the next edge.
REQ-023 In IDLE, f2a_id_req_i=1 with no request: remain in IDLE; no output changes.
REQ-024 Arbitration, step 1: only requesting channels with the minimum priority value are candidates.
REQ-025 Arbitration, step 2: among candidates, pick the first channel at or after rr_ptr, scanning upward modulo NUM_CH.
REQ-026 Actions on entering XFER, all registered in the same edge:
- latch winner into a2f_id_o;
- latch winner's pkglen code into a2f_pkglen_sel_o;
- load beat counter with code+1;
- set a2f_gnt_o=1.
REQ-027 Grant latency: exactly one cycle from the f2a_id_req_i sample edge to a2f_gnt_o=1.
REQ-028 In XFER, a2f_val_o = slv_val_i[a2f_id_o] and a2f_data_o = slv_data_i[a2f_id_o], both combinational.
REQ-029 In XFER, a2s_ack_o[a2f_id_o] = f2a_ack_i & a2f_val_o; all other a2s_ack_o bits are 0.
REQ-030 A beat completes when a2f_val_o=1 and f2a_ack_i=1 in the same cycle; the beat counter decrements by 1.
REQ-031 Last beat (counter=1 and beat completes), on the next edge:
- go to IDLE;
- clear a2f_gnt_o;
- set rr_ptr = (a2f_id_o+1) mod NUM_CH.
REQ-032 In XFER, f2a_id_req_i, slv_req_i, slv_prio_i and slv_pkglen_i changes are ignored; the grant holds until all beats complete, even if the granted channel drops its request.
REQ-033 Back-to-back packets: f2a_id_req_i in the first IDLE cycle after XFER grants again with one-cycle latency; no dead cycle beyond that IDLE cycle.
REQ-034 Outside XFER:
- a2f_val_o=0;
- a2f_data_o=0;
- a2s_ack_o=0.
REQ-035 a2f_id_o and a2f_pkglen_sel_o hold their last values in IDLE.
REQ-036 rr_ptr changes only on packet completion; on arbitration without completion it is unchanged.

Reset
REQ-037 rstn_i low, asynchronous, at any time including mid-packet; the block enters IDLE with these values:
- a2f_gnt_o=0, a2f_id_o=0, a2f_pkglen_sel_o=0;
- beat counter=0, rr_ptr=0;
- a2f_val_o=0, a2f_data_o=0, a2s_ack_o=0.
REQ-038 After rstn_i deasserts, the first arbitration occurs no earlier than the first rising edge with rstn_i=1.

Verification
REQ-039 Fixed priority: NUM_CH=4, prio={3,2,1,0} for ch3..ch0, all requesting, f2a_id_req_i pulse -> a2f_id_o=0, a2f_gnt_o=1 one cycle later.
REQ-040 Round robin on equal priority: all prio=1, all requesting, pkglen=0, four consecutive grants -> ids 0,1,2,3, then 0.
REQ-041 Packet length hold: ch2 pkglen=3, val stalls one cycle mid-packet -> exactly 4 acked beats, then IDLE; grant does not move on the stall.
REQ-042 Mid-packet changes: ch1 prio drops to 0 and f2a_id_req_i pulses during XFER of ch3 -> ch3 completes; ch1 is granted on the next request.
REQ-043 Reset mid-operation: rstn_i low at beat 2 of 5 -> all outputs 0 immediately; the next grant starts from rr_ptr=0.
REQ-044 Parametric: NUM_CH=2 and NUM_CH=8 with DW=64 -> correct id, data and ack routing for every channel.
